uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
// - UART transmitter; the transmit-side counterpart of the UART RX FSM/sampler path. Same frame format and clocking.
// - Accepts a parallel byte with a one-cycle valid strobe while idle.
// - Serialises start bit, data LSB-first, optional parity and one stop bit onto TX_OUT.
// - Each bit is held for `prescale` cycles of the oversampled clock clk_based_on_prescale.
// - Parity and prescale settings match the RX side; a loopback to uart_rx must recover the byte.
// PARAMETERS
// - DATA_WIDTH      8  data bits per frame
// - PRESCALE_WIDTH  6  width of the prescale input (max 63 cycles/bit)
// PORTS
// - clk_based_on_prescale  in   1               oversampled clock (prescale x baud)
// - asy_reset              in   1               asynchronous, active-low reset
// - P_DATA                 in   DATA_WIDTH      byte to send; sampled on accept
// - data_valid             in   1               request strobe; accepted only when busy==0
// - parity_enable          in   1               1 = insert parity bit; sampled on accept
// - parity_type            in   1               0 = even, 1 = odd; sampled on accept
// - prescale               in   PRESCALE_WIDTH  cycles per bit; sampled on accept; 0 treated as 1
// - TX_OUT                 out  1               serial line, idle high
// - busy                   out  1               1 while a frame is on the line
// BEHAVIOUR
// - Reset (async, any time, including mid-frame):
//   - TX_OUT=1, busy=0, state=IDLE.
//   - All counters and latched config cleared. The partial frame is abandoned.
// - Outputs are registered; no combinational path from inputs to TX_OUT or busy.
// - Accept: posedge with state==IDLE and data_valid==1.
//   - Latch P_DATA, parity_enable, parity_type and prescale.
//   - Parity = ^P_DATA, XORed with parity_type.
//   - Next cycle: TX_OUT=0 (start bit), busy=1.
// - data_valid while busy==1: ignored. No queuing, no effect on the current frame.
// - FSM states IDLE, START, DATA, PARITY, STOP.
//   - IDLE -> START on accept.
//   - START -> DATA after prescale cycles.
//   - DATA sends bit_cnt = 0..DATA_WIDTH-1, LSB first. Each bit lasts prescale cycles.
//   - After the last data bit: -> PARITY if the latched parity_enable==1, else -> STOP.
//   - PARITY -> STOP after prescale cycles.
//   - STOP drives TX_OUT=1 for prescale cycles, then -> IDLE.
// - Timing counters:
//   - edge_cnt counts 0..prescale-1 within each bit and wraps to 0 on each bit boundary.
//   - bit_cnt advances only on edge_cnt wrap.
// - busy:
//   - High exactly prescale*(DATA_WIDTH+2+parity_enable) cycles, i.e. 80 or 88 cycles at prescale=8.
//   - Drops on the cycle the FSM re-enters IDLE.
// - Back-to-back frames: a new accept is possible on the first IDLE cycle, giving a minimum one-cycle gap.
// - Input changes mid-frame (P_DATA, parity or prescale): no effect; latched copies are used.
// TESTING
// 1. prescale=8, parity off, P_DATA=8'hA5, one data_valid pulse:
//    - TX_OUT bits 0,1,0,1,0,0,1,0,1,1, each exactly 8 cycles.
//    - busy high 80 cycles.
// 2. prescale=8, parity on, even, P_DATA=8'hA5:
//    - parity bit 0; 11 bits total; busy 88 cycles.
//    - Same with odd parity: parity bit 1.
// 3. prescale=16, parity on, odd, P_DATA=8'hFF:
//    - bits 0,1x8,1(parity),1(stop), each 16 cycles; busy 176 cycles.
// 4. Mid-frame data_valid=1 with P_DATA=8'h3C during the 8'hA5 frame:
//    - A5 frame unchanged.
//    - No second frame; busy=0 after 80 cycles.
// 5. asy_reset low in DATA bit 3:
//    - TX_OUT=1 and busy=0 immediately.
//    - After release, a fresh 8'h5A frame is sent correctly.
// 6. Loopback to uart_rx (same prescale/parity), frames 8'h00, 8'hFF, 8'h81:
//    - RX data_valid asserted with matching byte; no parity or stop error.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity
// bit and one stop bit. Each bit is held for `prescale` cycles of the
// oversampled clock. The frame configuration is latched when a byte is
// accepted, so input changes during a frame have no effect on it.
//
// Handshake: data_valid is a request strobe. It is accepted on a rising clock
// edge only while the FSM is in IDLE (busy==0). While busy==1 the strobe is
// ignored and nothing is queued. busy rises on the cycle after the accept and
// falls on the cycle the FSM re-enters IDLE.
module uart_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk_based_on_prescale,
  input  logic                      asy_reset,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      data_valid,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      TX_OUT,
  output logic                      busy,
  output logic [2:0]                o_dbg_state
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0]            LAST_BIT = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0]            BC_ONE   = BCW'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PS_ONE   = PRESCALE_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                    r_state;
  logic [DATA_WIDTH-1:0]     r_data;
  logic                      r_parity_en;
  logic                      r_parity_bit;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
  logic [BCW-1:0]            r_bit_cnt;

  logic                      w_bit_done;
  logic [BCW-1:0]            w_next_bit;

  // Last cycle of the current bit period and index of the following data bit.
  assign w_bit_done = (r_edge_cnt == (r_prescale - PS_ONE));
  assign w_next_bit = r_bit_cnt + BC_ONE;

  assign o_dbg_state = r_state;

  // Frame FSM with registered line and busy outputs.
  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      r_state      <= IDLE;
      r_data       <= '0;
      r_parity_en  <= 1'b0;
      r_parity_bit <= 1'b0;
      r_prescale   <= PS_ONE;
      r_edge_cnt   <= '0;
      r_bit_cnt    <= '0;
      TX_OUT       <= 1'b1;
      busy         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_edge_cnt <= '0;
          r_bit_cnt  <= '0;
          TX_OUT     <= 1'b1;
          busy       <= 1'b0;
          if (data_valid) begin
            r_data       <= P_DATA;
            r_parity_en  <= parity_enable;
            r_parity_bit <= (^P_DATA) ^ parity_type;
            // A prescale of zero would never wrap; run it as one cycle per bit.
            r_prescale   <= (prescale == '0) ? PS_ONE : prescale;
            r_state      <= START;
            TX_OUT       <= 1'b0;
            busy         <= 1'b1;
          end
        end
        START: begin
          if (w_bit_done) begin
            r_edge_cnt <= '0;
            r_state    <= DATA;
            TX_OUT     <= r_data[0];
          end else begin
            r_edge_cnt <= r_edge_cnt + PS_ONE;
          end
        end
        DATA: begin
          if (w_bit_done) begin
            r_edge_cnt <= '0;
            if (r_bit_cnt == LAST_BIT) begin
              if (r_parity_en) begin
                r_state <= PARITY;
                TX_OUT  <= r_parity_bit;
              end else begin
                r_state <= STOP;
                TX_OUT  <= 1'b1;
              end
            end else begin
              r_bit_cnt <= w_next_bit;
              TX_OUT    <= r_data[w_next_bit];
            end
          end else begin
            r_edge_cnt <= r_edge_cnt + PS_ONE;
          end
        end
        PARITY: begin
          if (w_bit_done) begin
            r_edge_cnt <= '0;
            r_state    <= STOP;
            TX_OUT     <= 1'b1;
          end else begin
            r_edge_cnt <= r_edge_cnt + PS_ONE;
          end
        end
        STOP: begin
          if (w_bit_done) begin
            r_edge_cnt <= '0;
            r_state    <= IDLE;
            TX_OUT     <= 1'b1;
            busy       <= 1'b0;
          end else begin
            r_edge_cnt <= r_edge_cnt + PS_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          TX_OUT  <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table of directed frames, hand-written corner sequences
// (mid-frame strobe, mid-frame reset, back-to-back) and randomized frames,
// all checked against a frame model built from the line protocol rules.
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] p_data;
  logic       data_valid;
  logic       parity_enable;
  logic       parity_type;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk_based_on_prescale (clk),
    .asy_reset             (rst_n),
    .P_DATA                (p_data),
    .data_valid            (data_valid),
    .parity_enable         (parity_enable),
    .parity_type           (parity_type),
    .prescale              (prescale),
    .TX_OUT                (tx_out),
    .busy                  (busy),
    .o_dbg_state           (dbg_state)
  );

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends one frame and checks it against the line model. Called right after
  // a falling edge; returns right after a falling edge.
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                           input logic [5:0] p, input int exp_len, input logic exp_par,
                           input int disturb_at, input int idle_after, input string tag);
    int         pp;
    int         nb;
    int         blen;
    int         s;
    int         ok;
    logic [0:0] exp_q[$];
    logic       tx_s[$];
    logic [7:0] rx_byte;
    pp = (p == 6'd0) ? 1 : int'(p);
    exp_q = {};
    tx_s  = {};
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back((($countones(d) % 2) == 1) ^ pt);
    exp_q.push_back(1'b1);
    nb = exp_q.size();

    p_data        = d;
    parity_enable = pe;
    parity_type   = pt;
    prescale      = p;
    data_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;

    blen = 0;
    while (busy === 1'b1 && blen < 1000) begin
      tx_s.push_back(tx_out);
      blen++;
      if (blen == disturb_at) begin
        p_data        = 8'h3C;
        parity_enable = ~pe;
        parity_type   = ~pt;
        prescale      = 6'd3;
        data_valid    = 1'b1;
      end
      @(negedge clk);
      data_valid = 1'b0;
    end

    check($sformatf("%s busy_len", tag), blen, exp_len);
    for (int b = 0; b < nb; b++) begin
      ok = 1;
      for (int j = 0; j < pp; j++) begin
        s = b * pp + j;
        if (s >= tx_s.size()) ok = 0;
        else if (tx_s[s] !== exp_q[b]) ok = 0;
      end
      check($sformatf("%s bit%0d_held_%0d_cycles", tag, b, pp), ok, 1);
    end

    // Mid-bit sampling receiver: recover the byte, parity and stop bit.
    rx_byte = 8'h00;
    for (int i = 0; i < 8; i++) begin
      s = (i + 1) * pp + pp / 2;
      rx_byte[i] = (s < tx_s.size()) ? tx_s[s] : 1'bx;
    end
    check($sformatf("%s rx_byte", tag), rx_byte, d);
    if (pe) begin
      s = 9 * pp + pp / 2;
      check($sformatf("%s rx_parity", tag), (s < tx_s.size()) ? tx_s[s] : 1'bx, exp_par);
    end
    s = (nb - 1) * pp + pp / 2;
    check($sformatf("%s rx_stop", tag), (s < tx_s.size()) ? tx_s[s] : 1'bx, 1);

    check($sformatf("%s idle_tx", tag), tx_out, 1);
    check($sformatf("%s idle_busy", tag), busy, 0);
    for (int k = 0; k < idle_after; k++) begin
      @(negedge clk);
      check($sformatf("%s post_busy%0d", tag, k), busy, 0);
      check($sformatf("%s post_tx%0d", tag, k), tx_out, 1);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic [5:0] p;
    int         len;
    logic       par;
  } vec_t;

  vec_t vecs[9];

  // Stimulus sequence and final report.
  initial begin
    logic [7:0] rd;
    logic       rpe;
    logic       rpt;
    logic [5:0] rp;
    int         rpp;
    rst_n         = 1'b0;
    p_data        = 8'h00;
    data_valid    = 1'b0;
    parity_enable = 1'b0;
    parity_type   = 1'b0;
    prescale      = 6'd8;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 6'd8,  80,  1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 6'd8,  88,  1'b0};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 6'd8,  88,  1'b1};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 6'd16, 176, 1'b1};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 6'd8,  80,  1'b0};
    vecs[5] = '{8'h81, 1'b1, 1'b0, 6'd8,  88,  1'b0};
    vecs[6] = '{8'h5A, 1'b0, 1'b0, 6'd1,  10,  1'b0};
    vecs[7] = '{8'h81, 1'b1, 1'b1, 6'd0,  11,  1'b1};
    vecs[8] = '{8'h00, 1'b1, 1'b1, 6'd63, 693, 1'b1};

    #12;
    check("reset tx", tx_out, 1);
    check("reset busy", busy, 0);
    check("reset state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset data_valid_low busy", busy, 0);

    for (int v = 0; v < 9; v++) begin
      run_frame(vecs[v].d, vecs[v].pe, vecs[v].pt, vecs[v].p, vecs[v].len, vecs[v].par,
                0, 2, $sformatf("vec%0d", v));
    end

    // Strobe with different inputs in the middle of an A5 frame.
    run_frame(8'hA5, 1'b0, 1'b0, 6'd8, 80, 1'b0, 20, 12, "midframe_strobe");

    // Reset during data bit 3 (line bit 4, cycle 3 of that bit).
    p_data = 8'hA5; parity_enable = 1'b0; parity_type = 1'b0; prescale = 6'd8;
    data_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
    repeat (35) @(negedge clk);
    check("pre_reset data_bit3", tx_out, 0);
    check("pre_reset busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset tx", tx_out, 1);
    check("async_reset busy", busy, 0);
    check("async_reset state", dbg_state, 0);
    @(negedge clk);
    @(negedge clk);
    check("held_reset tx", tx_out, 1);
    check("held_reset busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(8'h5A, 1'b0, 1'b0, 6'd8, 80, 1'b0, 0, 2, "after_midframe_reset");

    // Back-to-back: second request lands on the first IDLE cycle.
    run_frame(8'hC3, 1'b1, 1'b0, 6'd4, 44, 1'b0, 0, 0, "b2b_first");
    run_frame(8'h3C, 1'b0, 1'b1, 6'd4, 40, 1'b0, 0, 1, "b2b_second");

    // Randomized frames against the model.
    for (int r = 0; r < 16; r++) begin
      rd  = 8'($urandom_range(0, 255));
      rpe = 1'($urandom_range(0, 1));
      rpt = 1'($urandom_range(0, 1));
      rp  = 6'($urandom_range(0, 12));
      rpp = (rp == 6'd0) ? 1 : int'(rp);
      run_frame(rd, rpe, rpt, rp, rpp * (10 + int'(rpe)),
                (($countones(rd) % 2) == 1) ^ rpt,
                (r % 3 == 0) ? 5 : 0, int'($urandom_range(0, 2)),
                $sformatf("rand%0d_%02h", r, rd));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
